snake_cell_plotter: RTL and testbench

- Consumer end of the game-logic draw stream, i.e. the x_out, y_out, status and plot outputs of the RAM/game controller.
- Buffers incoming cell-draw requests in a small FIFO.
- Expands each request into a CELL_SIZE x CELL_SIZE pixel block, with colour chosen by cell type.
- Drives the VGA adapter pixel-write interface.
- After reset, clears the whole screen before drawing any cell.

---
 rtl/snake_cell_plotter_if.sv | 25 ++
 rtl/snake_cell_plotter.sv | 159 +++++++++++++++
 tb/tb_snake_cell_plotter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_cell_plotter_if.sv
// Request stream from the game controller and the pixel-write port to the VGA adapter.
// The master side issues cell requests; the slave side is the plotter.
interface snake_cell_plotter_if;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [1:0] type_in;
  logic       plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       writeEn;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  modport master (
    output x_in, y_in, type_in, plot,
    input  vga_x, vga_y, colour, writeEn, busy, fifo_full, overflow
  );

  modport slave (
    input  x_in, y_in, type_in, plot,
    output vga_x, vga_y, colour, writeEn, busy, fifo_full, overflow
  );
endinterface

// File: rtl/snake_cell_plotter.sv
// Buffers cell-draw requests and expands each into a CELL_SIZE x CELL_SIZE pixel block.
// After reset the whole screen is swept with the background colour before any cell is drawn.
module snake_cell_plotter #(
  parameter int          CELL_LOG2    = 2,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [2:0]  BG_COLOUR    = 3'b000,
  parameter logic [2:0]  SNAKE_COLOUR = 3'b010,
  parameter logic [2:0]  FOOD_COLOUR  = 3'b100,
  parameter logic [2:0]  WALL_COLOUR  = 3'b111
) (
  input  logic                 clk,
  input  logic                 reset,
  snake_cell_plotter_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, DRAW} state_t;

  state_t state_reg, state_next;

  logic [16:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]       count_reg;
  logic                 overflow_reg;

  logic [7:0]           sweep_x_reg;
  logic [6:0]           sweep_y_reg;
  logic [CELL_LOG2-1:0] dx_reg, dy_reg;
  logic [7:0]           x0_reg;
  logic [6:0]           y0_reg;
  logic [1:0]           typ_reg;

  logic                 fifo_empty, fifo_full, push, pop;
  logic                 sweep_last, cell_last;
  logic [8:0]           sum_x;
  logic [7:0]           sum_y;
  logic [2:0]           cell_colour;

  // fifo_full is the registered occupancy, so a same-cycle pop never frees room for a push
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign push       = bus.plot & ~fifo_full;
  assign pop        = (state_reg == IDLE) & ~fifo_empty;

  assign sweep_last = (sweep_x_reg == 8'(SCREEN_W - 1)) && (sweep_y_reg == 7'(SCREEN_H - 1));
  assign cell_last  = (&dx_reg) & (&dy_reg);

  // One bit wider than the coordinate so cells near the right/bottom edge clip instead of wrapping
  assign sum_x = {1'b0, x0_reg} + 9'(dx_reg);
  assign sum_y = {1'b0, y0_reg} + 8'(dy_reg);

  always_comb begin
    cell_colour = BG_COLOUR;
    case (typ_reg)
      2'd1:    cell_colour = SNAKE_COLOUR;
      2'd2:    cell_colour = FOOD_COLOUR;
      2'd3:    cell_colour = WALL_COLOUR;
      default: cell_colour = BG_COLOUR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.x_in, bus.y_in, bus.type_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CLEAR;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      sweep_x_reg  <= '0;
      sweep_y_reg  <= '0;
      dx_reg       <= '0;
      dy_reg       <= '0;
      x0_reg       <= '0;
      y0_reg       <= '0;
      typ_reg      <= '0;
    end else begin
      state_reg <= state_next;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (bus.plot && fifo_full) begin
        overflow_reg <= 1'b1;
      end
      if (pop) begin
        rd_ptr_reg                 <= rd_ptr_reg + 1'b1;
        {x0_reg, y0_reg, typ_reg}  <= fifo_mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (state_reg == CLEAR) begin
        if (sweep_x_reg == 8'(SCREEN_W - 1)) begin
          sweep_x_reg <= '0;
          sweep_y_reg <= sweep_last ? '0 : sweep_y_reg + 1'b1;
        end else begin
          sweep_x_reg <= sweep_x_reg + 1'b1;
        end
      end

      // dx/dy wrap naturally back to zero on the last pixel of a cell
      if (pop) begin
        dx_reg <= '0;
        dy_reg <= '0;
      end else if (state_reg == DRAW) begin
        dx_reg <= dx_reg + 1'b1;
        if (&dx_reg) begin
          dy_reg <= dy_reg + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    bus.writeEn = 1'b0;
    bus.vga_x   = sweep_x_reg;
    bus.vga_y   = sweep_y_reg;
    bus.colour  = BG_COLOUR;
    case (state_reg)
      CLEAR: begin
        bus.writeEn = 1'b1;
        if (sweep_last) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (!fifo_empty) begin
          state_next = DRAW;
        end
      end
      DRAW: begin
        bus.vga_x   = sum_x[7:0];
        bus.vga_y   = sum_y[6:0];
        bus.colour  = cell_colour;
        bus.writeEn = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
        if (cell_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign bus.busy      = (state_reg != IDLE) | ~fifo_empty;
  assign bus.fifo_full = fifo_full;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_snake_cell_plotter.sv
// Random cell requests checked by a cycle-stamped pixel scoreboard against a queue-based model
// of the plotter (clear sweep, request queue, 16-cycle cell expansion with clipping).
module tb_snake_cell_plotter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  snake_cell_plotter_if bus();

  snake_cell_plotter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int x;
    int y;
    int col;
  } pix_t;

  typedef struct {
    int x;
    int y;
    int t;
  } req_t;

  pix_t exp_q[$];
  req_t req_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit started = 0;
  int clear_left = 0;
  int draw_left = 0;
  bit m_ovf = 0;
  bit idle_pre;
  bit full_pre;

  function automatic int colour_of(int t);
    case (t)
      1:       return 2;
      2:       return 4;
      3:       return 7;
      default: return 0;
    endcase
  endfunction

  // Reference model: advances once per rising edge using the inputs seen at that edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        started    = 1;
        req_q.delete();
        exp_q.delete();
        m_ovf      = 0;
        draw_left  = 0;
        clear_left = 160 * 120;
        for (int i = 0; i < 160 * 120; i++) begin
          exp_q.push_back('{cyc: cyc + i, x: i % 160, y: i / 160, col: 0});
        end
        $display("[TB] cycle %0d reset: screen clear expected", cyc);
      end else if (started) begin
        idle_pre = (clear_left == 0) && (draw_left == 0);
        full_pre = (req_q.size() == 8);
        if (clear_left > 0) clear_left--;
        if (draw_left > 0) draw_left--;
        if (idle_pre && req_q.size() > 0) begin
          req_t r;
          r = req_q.pop_front();
          draw_left = 16;
          for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
              if (r.x + dx < 160 && r.y + dy < 120) begin
                exp_q.push_back('{cyc: cyc + dy * 4 + dx, x: r.x + dx, y: r.y + dy,
                                  col: colour_of(r.t)});
              end
            end
          end
          $display("[TB] cycle %0d draw cell (%0d,%0d) type %0d", cyc, r.x, r.y, r.t);
        end
        if (bus.plot) begin
          if (full_pre) begin
            m_ovf = 1;
            $display("[TB] cycle %0d request (%0d,%0d) type %0d dropped", cyc,
                     int'(bus.x_in), int'(bus.y_in), int'(bus.type_in));
          end else begin
            req_q.push_back('{x: int'(bus.x_in), y: int'(bus.y_in), t: int'(bus.type_in)});
            $display("[TB] cycle %0d request (%0d,%0d) type %0d queued", cyc,
                     int'(bus.x_in), int'(bus.y_in), int'(bus.type_in));
          end
        end
      end
    end
  end

  // Monitor: samples DUT outputs on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (started && !reset) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          tests++;
          fails++;
          $display("FAIL missing_pixel cycle %0d: no write seen, required (%0d,%0d) colour %0d at cycle %0d",
                   cyc, exp_q[0].x, exp_q[0].y, exp_q[0].col, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        tests++;
        if (bus.writeEn === 1'b1) begin
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            pix_t p;
            p = exp_q.pop_front();
            if (bus.vga_x !== 8'(p.x) || bus.vga_y !== 7'(p.y) || bus.colour !== 3'(p.col)) begin
              fails++;
              $display("FAIL pixel cycle %0d: got (%0d,%0d) colour %0d, required (%0d,%0d) colour %0d",
                       cyc, bus.vga_x, bus.vga_y, bus.colour, p.x, p.y, p.col);
            end
          end else begin
            fails++;
            $display("FAIL unexpected_write cycle %0d: got write at (%0d,%0d), required no write",
                     cyc, bus.vga_x, bus.vga_y);
          end
        end else if (bus.writeEn !== 1'b0) begin
          fails++;
          $display("FAIL writeEn cycle %0d: got %b, required 0 or 1", cyc, bus.writeEn);
        end
        tests++;
        if (bus.busy !== ((clear_left > 0) || (draw_left > 0) || (req_q.size() > 0))) begin
          fails++;
          $display("FAIL busy cycle %0d: got %b, required %0d", cyc, bus.busy,
                   (clear_left > 0) || (draw_left > 0) || (req_q.size() > 0));
        end
        tests++;
        if (bus.fifo_full !== (req_q.size() == 8)) begin
          fails++;
          $display("FAIL fifo_full cycle %0d: got %b, required %0d", cyc, bus.fifo_full,
                   req_q.size() == 8);
        end
        tests++;
        if (bus.overflow !== m_ovf) begin
          fails++;
          $display("FAIL overflow cycle %0d: got %b, required %0d", cyc, bus.overflow, m_ovf);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input int t);
    bus.plot    = 1'b1;
    bus.x_in    = 8'(x);
    bus.y_in    = 7'(y);
    bus.type_in = 2'(t);
    tick();
    bus.plot    = 1'b0;
  endtask

  task automatic rand_req();
    bus.x_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 159));
    bus.y_in    = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 119));
    bus.type_in = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 25000) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 25000) begin
      fails++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", bus.busy, n);
    end
  endtask

  initial begin
    bus.plot    = 1'b0;
    bus.x_in    = '0;
    bus.y_in    = '0;
    bus.type_in = '0;

    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Requests arriving mid-clear must wait for the sweep to finish
    repeat (100) tick();
    for (int i = 0; i < 3; i++) begin
      rand_req();
      bus.plot = 1'b1;
      tick();
    end
    bus.plot = 1'b0;
    wait_idle();

    send(8, 4, 1);
    wait_idle();
    send(158, 118, 2);
    wait_idle();

    // Ten consecutive requests: one pops, eight fill the FIFO, the last is dropped
    for (int i = 0; i < 10; i++) begin
      rand_req();
      bus.plot = 1'b1;
      tick();
    end
    bus.plot = 1'b0;
    wait_idle();

    repeat (400) begin
      rand_req();
      bus.plot = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.plot = 1'b0;
    wait_idle();

    // Reset during the sixth pixel of a cell with two more queued
    for (int i = 0; i < 3; i++) begin
      rand_req();
      bus.plot = 1'b1;
      tick();
    end
    bus.plot = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle();

    repeat (5) tick();
    send(40, 60, 3);
    send(0, 0, 1);
    wait_idle();
    repeat (3) tick();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_pixels: got %0d undrawn, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
